// File: rtl/uart_link_if.sv
// rtl/uart_link_if.sv - UART link bundle: serial lines, TX/RX FIFO access and error flags
//
// Purpose: groups every uart_link signal except clk/rst so the host side and
// the transceiver share one typed connection.
// Ports (slave = transceiver side):
//   rxIn, txOut              serial lines
//   txWrEn, txWrData         TX FIFO push
//   txFull, txLevel, txBusy  TX status
//   rxRdEn, rxRdData         RX FIFO pop / show-ahead head
//   rxEmpty, rxLevel         RX status
//   errClr                   clears sticky flags
//   frameErr, parityErr, overrunErr  sticky error flags
interface uart_link_if #(
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
);
    logic                        rxIn;
    logic                        txOut;
    logic                        txWrEn;
    logic [DATA_BITS-1:0]        txWrData;
    logic                        txFull;
    logic [$clog2(TX_DEPTH):0]   txLevel;
    logic                        txBusy;
    logic                        rxRdEn;
    logic [DATA_BITS-1:0]        rxRdData;
    logic                        rxEmpty;
    logic [$clog2(RX_DEPTH):0]   rxLevel;
    logic                        errClr;
    logic                        frameErr;
    logic                        parityErr;
    logic                        overrunErr;

    modport slave (
        input  rxIn, txWrEn, txWrData, rxRdEn, errClr,
        output txOut, txFull, txLevel, txBusy, rxRdData, rxEmpty, rxLevel,
               frameErr, parityErr, overrunErr
    );

    modport master (
        output rxIn, txWrEn, txWrData, rxRdEn, errClr,
        input  txOut, txFull, txLevel, txBusy, rxRdData, rxEmpty, rxLevel,
               frameErr, parityErr, overrunErr
    );
endinterface

// File: rtl/uart_link.sv
// rtl/uart_link.sv - parametrised UART transceiver with TX/RX FIFOs and sticky error flags
//
// Purpose: 16x-oversampled UART, DATA_BITS 5..8, optional odd/even parity,
// 1 or 2 stop bits, show-ahead RX FIFO, framing/parity/overrun reporting.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  uart_link_if.slave (serial lines, FIFO access, status, error flags)
module uart_link #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BPS       = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    uart_link_if.slave bus
);
    localparam int DIV_R = (CLK_FREQ + BPS * 8) / (BPS * 16);
    localparam int DIV   = (DIV_R < 1) ? 1 : DIV_R;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TAW   = $clog2(TX_DEPTH);
    localparam int RAW   = $clog2(RX_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] r_tx_mem [TX_DEPTH];
    logic [TAW-1:0]       r_tx_wp, r_tx_rp;
    logic [TAW:0]         r_tx_level;
    logic                 w_tx_full, w_tx_push, w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_tx_full = (r_tx_level == (TAW+1)'(TX_DEPTH));
    assign w_tx_push = bus.txWrEn && !w_tx_full;
    assign w_tx_head = r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.txWrData;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_level <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TAW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TAW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_level <= r_tx_level + (TAW+1)'(1);
                2'b01:   r_tx_level <= r_tx_level - (TAW+1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    state_t               r_tx_state;
    logic [DW-1:0]        r_tx_div;
    logic [3:0]           r_tx_tcnt;
    logic [2:0]           r_tx_bcnt;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_tx_out, r_tx_busy;
    logic                 w_tx_tick, w_tx_bit_end, w_tx_last_stop;

    assign w_tx_tick      = (r_tx_div == DW'(DIV - 1));
    assign w_tx_bit_end   = w_tx_tick && (r_tx_tcnt == 4'd15);
    assign w_tx_last_stop = (r_tx_state == S_STOP) && w_tx_bit_end && (r_tx_bcnt == 3'(STOP_BITS - 1));
    // Popping at the end of the last stop bit gives back-to-back frames.
    assign w_tx_pop       = (r_tx_level != '0) && ((r_tx_state == S_IDLE) || w_tx_last_stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_div   <= '0;
            r_tx_tcnt  <= '0;
            r_tx_bcnt  <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            if (r_tx_state == S_IDLE) begin
                r_tx_div  <= '0;
                r_tx_tcnt <= '0;
            end else if (w_tx_tick) begin
                r_tx_div  <= '0;
                r_tx_tcnt <= r_tx_tcnt + 4'd1;
            end else begin
                r_tx_div  <= r_tx_div + DW'(1);
            end

            if (w_tx_pop) begin
                r_tx_shift <= w_tx_head;
                r_tx_par   <= par_of(w_tx_head);
                r_tx_out   <= 1'b0;
                r_tx_busy  <= 1'b1;
                r_tx_state <= S_START;
            end else begin
                case (r_tx_state)
                    S_START: if (w_tx_bit_end) begin
                        r_tx_out   <= r_tx_shift[0];
                        r_tx_bcnt  <= '0;
                        r_tx_state <= S_DATA;
                    end
                    S_DATA: if (w_tx_bit_end) begin
                        if (r_tx_bcnt == 3'(DATA_BITS - 1)) begin
                            r_tx_bcnt <= '0;
                            if (PARITY != 0) begin
                                r_tx_out   <= r_tx_par;
                                r_tx_state <= S_PARITY;
                            end else begin
                                r_tx_out   <= 1'b1;
                                r_tx_state <= S_STOP;
                            end
                        end else begin
                            r_tx_bcnt  <= r_tx_bcnt + 3'd1;
                            r_tx_out   <= r_tx_shift[1];
                            r_tx_shift <= r_tx_shift >> 1;
                        end
                    end
                    S_PARITY: if (w_tx_bit_end) begin
                        r_tx_out   <= 1'b1;
                        r_tx_state <= S_STOP;
                    end
                    S_STOP: if (w_tx_bit_end) begin
                        if (w_tx_last_stop) begin
                            r_tx_busy  <= 1'b0;
                            r_tx_state <= S_IDLE;
                        end else begin
                            r_tx_bcnt  <= r_tx_bcnt + 3'd1;
                        end
                    end
                    default: r_tx_state <= S_IDLE;
                endcase
            end
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] r_rx_mem [RX_DEPTH];
    logic [RAW-1:0]       r_rx_wp, r_rx_rp;
    logic [RAW:0]         r_rx_level;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 w_rx_full, w_rx_pop, w_rx_push, w_stop_sample;
    logic                 r_rx_s1, r_rx_s2, r_rx_s3;

    assign w_rx_full = (r_rx_level == (RAW+1)'(RX_DEPTH));
    assign w_rx_pop  = bus.rxRdEn && (r_rx_level != '0);
    // A pop in the stop-sample cycle frees the slot the new character needs.
    assign w_rx_push = w_stop_sample && r_rx_s2 && (!w_rx_full || w_rx_pop);

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_level <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + RAW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RAW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_level <= r_rx_level + (RAW+1)'(1);
                2'b01:   r_rx_level <= r_rx_level - (RAW+1)'(1);
                default: ;
            endcase
        end
    end

    // ---------------- RX FSM ----------------
    state_t        r_rx_state;
    logic [DW-1:0] r_rx_div;
    logic [3:0]    r_rx_tcnt;
    logic [2:0]    r_rx_bcnt;
    logic          r_rx_par_bad, r_frame_err, r_parity_err, r_overrun_err;
    logic          w_rx_tick;

    assign w_rx_tick     = (r_rx_div == DW'(DIV - 1));
    assign w_stop_sample = (r_rx_state == S_STOP) && w_rx_tick && (r_rx_tcnt == 4'd15);

    // r_rx_s3 is the previous synchronized value, used only for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1       <= 1'b1;
            r_rx_s2       <= 1'b1;
            r_rx_s3       <= 1'b1;
            r_rx_state    <= S_IDLE;
            r_rx_div      <= '0;
            r_rx_tcnt     <= '0;
            r_rx_bcnt     <= '0;
            r_rx_shift    <= '0;
            r_rx_par_bad  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_rx_s1 <= bus.rxIn;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;

            if (bus.errClr) begin
                r_frame_err   <= 1'b0;
                r_parity_err  <= 1'b0;
                r_overrun_err <= 1'b0;
            end

            if (r_rx_state == S_IDLE) begin
                r_rx_div  <= '0;
                r_rx_tcnt <= '0;
            end else if (w_rx_tick) begin
                r_rx_div  <= '0;
                r_rx_tcnt <= r_rx_tcnt + 4'd1;
            end else begin
                r_rx_div  <= r_rx_div + DW'(1);
            end

            // Start is checked half a bit in; afterwards every sample lands 16 ticks later.
            case (r_rx_state)
                S_IDLE: if (r_rx_s3 && !r_rx_s2) begin
                    r_rx_par_bad <= 1'b0;
                    r_rx_state   <= S_START;
                end
                S_START: if (w_rx_tick && r_rx_tcnt == 4'd7) begin
                    if (r_rx_s2) begin
                        r_rx_state <= S_IDLE;
                    end else begin
                        r_rx_tcnt  <= '0;
                        r_rx_bcnt  <= '0;
                        r_rx_state <= S_DATA;
                    end
                end
                S_DATA: if (w_rx_tick && r_rx_tcnt == 4'd15) begin
                    r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bcnt == 3'(DATA_BITS - 1))
                        r_rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        r_rx_bcnt <= r_rx_bcnt + 3'd1;
                end
                S_PARITY: if (w_rx_tick && r_rx_tcnt == 4'd15) begin
                    r_rx_par_bad <= (PARITY == 1) ? ~(^r_rx_shift ^ r_rx_s2) : (^r_rx_shift ^ r_rx_s2);
                    r_rx_state   <= S_STOP;
                end
                S_STOP: if (w_stop_sample) begin
                    if (!r_rx_s2) begin
                        r_frame_err <= 1'b1;
                        r_rx_state  <= S_BREAK;
                    end else begin
                        if (r_rx_par_bad)           r_parity_err  <= 1'b1;
                        if (w_rx_full && !w_rx_pop) r_overrun_err <= 1'b1;
                        r_rx_state <= S_IDLE;
                    end
                end
                S_BREAK: if (r_rx_s2) r_rx_state <= S_IDLE;
                default: r_rx_state <= S_IDLE;
            endcase
        end
    end

    assign bus.txOut      = r_tx_out;
    assign bus.txBusy     = r_tx_busy;
    assign bus.txFull     = w_tx_full;
    assign bus.txLevel    = r_tx_level;
    assign bus.rxEmpty    = (r_rx_level == '0);
    assign bus.rxLevel    = r_rx_level;
    assign bus.rxRdData   = (r_rx_level == '0) ? '0 : r_rx_mem[r_rx_rp];
    assign bus.frameErr   = r_frame_err;
    assign bus.parityErr  = r_parity_err;
    assign bus.overrunErr = r_overrun_err;
endmodule

// File: tb/tb_uart_link.sv
// tb/tb_uart_link.sv - scoreboard bench for uart_link (8N1 TX instance, 8E1 RX instance)
module tb_uart_link;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_link_if #(.DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16)) bus_n ();
    uart_link_if #(.DATA_BITS(8), .TX_DEPTH(16), .RX_DEPTH(16)) bus_e ();

    uart_link #(.CLK_FREQ(1_600_000), .BPS(100_000), .DATA_BITS(8), .PARITY(0),
                .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(16))
        u_n (.clk(clk), .rst(rst), .bus(bus_n.slave));
    uart_link #(.CLK_FREQ(1_600_000), .BPS(100_000), .DATA_BITS(8), .PARITY(2),
                .STOP_BITS(1), .TX_DEPTH(16), .RX_DEPTH(16))
        u_e (.clk(clk), .rst(rst), .bus(bus_e.slave));

    logic r_loop = 1'b0;
    logic r_line = 1'b1;
    assign bus_n.rxIn = 1'b1;
    assign bus_e.rxIn = r_loop ? bus_e.txOut : r_line;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] q_tx[$];
    logic [7:0] q_rx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit sel_e, input logic [7:0] d);
        tick();
        if (sel_e) begin bus_e.txWrEn = 1'b1; bus_e.txWrData = d; end
        else       begin bus_n.txWrEn = 1'b1; bus_n.txWrData = d; end
        tick();
        bus_e.txWrEn = 1'b0;
        bus_n.txWrEn = 1'b0;
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            r_line = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_inv, input int stop_low);
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(d[i], 16);
        drive(^d ^ par_inv, 16);
        if (stop_low > 0) drive(1'b0, 16 * stop_low);
        drive(1'b1, 16);
    endtask

    task automatic rd();
        tick();
        bus_e.rxRdEn = 1'b1;
        tick();
        bus_e.rxRdEn = 1'b0;
    endtask

    task automatic clr_err();
        tick();
        bus_e.errClr = 1'b1;
        tick();
        bus_e.errClr = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // TX monitor: decodes u_n frames at bit centres and scores them against q_tx.
    initial begin
        logic [7:0] d;
        logic sb, pb;
        forever begin
            @(negedge clk);
            if (!rst && bus_n.txOut === 1'b0) begin
                repeat (7) @(negedge clk);
                sb = bus_n.txOut;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    d[i] = bus_n.txOut;
                end
                repeat (16) @(negedge clk);
                pb = bus_n.txOut;
                if (q_tx.size() == 0) begin
                    check("tx_unexpected_frame", q_tx.size(), 1);
                end else begin
                    check("tx_byte", d, q_tx.pop_front());
                    check("tx_start_bit", sb, 0);
                    check("tx_stop_bit", pb, 1);
                end
            end
        end
    end

    // RX monitor: every accepted pop of u_e is scored against q_rx.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus_e.rxRdEn && !bus_e.rxEmpty) begin
                if (q_rx.size() == 0) check("rx_unexpected_pop", q_rx.size(), 1);
                else                  check("rx_byte", bus_e.rxRdData, q_rx.pop_front());
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        bus_n.txWrEn = 0; bus_n.txWrData = 0; bus_n.rxRdEn = 0; bus_n.errClr = 0;
        bus_e.txWrEn = 0; bus_e.txWrData = 0; bus_e.rxRdEn = 0; bus_e.errClr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        check("rst_txOut", bus_n.txOut, 1);
        check("rst_txBusy", bus_n.txBusy, 0);
        check("rst_txFull", bus_n.txFull, 0);
        check("rst_txLevel", bus_n.txLevel, 0);
        check("rst_rxEmpty", bus_e.rxEmpty, 1);
        check("rst_rxLevel", bus_e.rxLevel, 0);
        check("rst_rxRdData", bus_e.rxRdData, 0);
        check("rst_errs", {bus_e.frameErr, bus_e.parityErr, bus_e.overrunErr}, 0);

        // single 0xA5 frame, 8N1
        q_tx.push_back(8'hA5);
        push(0, 8'hA5);
        check("t1_level_n1", bus_n.txLevel, 1);
        check("t1_txOut_n1", bus_n.txOut, 1);
        tick();
        check("t1_txOut_n2", bus_n.txOut, 0);
        check("t1_busy_n2", bus_n.txBusy, 1);
        n = 0;
        while (bus_n.txBusy && n < 1000) begin n++; tick(); end
        check("t1_busy_cycles", n, 160);
        check("t1_level_end", bus_n.txLevel, 0);
        repeat (5) tick();

        // 17-byte burst, one ignored push while full
        c0 = 0;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 0) c0 = cyc;
            bus_n.txWrEn = 1'b1;
            bus_n.txWrData = (i < 17) ? 8'(i) : 8'hEE;
            if (i < 17) q_tx.push_back(8'(i));
            else        check("t2_full", bus_n.txFull, 1);
        end
        tick();
        bus_n.txWrEn = 1'b0;
        check("t2_level_after_ignored", bus_n.txLevel, 16);
        n = 0;
        while (bus_n.txBusy && n < 4000) begin n++; tick(); end
        check("t2_burst_cycles", cyc - c0, 2 + 17 * 160);
        repeat (20) tick();
        check("t2_all_frames_seen", q_tx.size(), 0);
        check("t2_level_end", bus_n.txLevel, 0);

        // loopback 0x3C with even parity
        r_loop = 1'b1;
        q_rx.push_back(8'h3C);
        push(1, 8'h3C);
        repeat (153) tick();
        check("t3_parity_bit", bus_e.txOut, 0);
        n = 0;
        while (bus_e.rxEmpty && n < 400) begin n++; tick(); end
        check("t3_rxEmpty", bus_e.rxEmpty, 0);
        check("t3_rxRdData", bus_e.rxRdData, 8'h3C);
        check("t3_parityErr", bus_e.parityErr, 0);
        rd();
        tick();
        check("t3_rxEmpty_after_rd", bus_e.rxEmpty, 1);
        n = 0;
        while (bus_e.txBusy && n < 400) begin n++; tick(); end
        r_loop = 1'b0;
        repeat (5) tick();

        // inverted parity bit: stored, flagged, then cleared
        q_rx.push_back(8'h81);
        send_frame(8'h81, 1, 0);
        repeat (4) tick();
        check("t4_parityErr", bus_e.parityErr, 1);
        check("t4_rxLevel", bus_e.rxLevel, 1);
        check("t4_frameErr", bus_e.frameErr, 0);
        rd();
        clr_err();
        check("t4_parityErr_clr", bus_e.parityErr, 0);

        // framing error with a 3-bit-time low stop, then a clean 0x12
        send_frame(8'h55, 0, 3);
        check("t5_frameErr", bus_e.frameErr, 1);
        check("t5_rxLevel", bus_e.rxLevel, 0);
        q_rx.push_back(8'h12);
        send_frame(8'h12, 0, 0);
        repeat (4) tick();
        check("t5_rxLevel_after", bus_e.rxLevel, 1);
        check("t5_frameErr_sticky", bus_e.frameErr, 1);
        rd();
        clr_err();
        check("t5_frameErr_clr", bus_e.frameErr, 0);

        // overrun: 17 frames with no reads
        for (int i = 0; i < 17; i++) begin
            if (i < 16) q_rx.push_back(8'(8'h40 + i));
            send_frame(8'(8'h40 + i), 0, 0);
        end
        repeat (4) tick();
        check("t6_rxLevel_full", bus_e.rxLevel, 16);
        check("t6_overrunErr", bus_e.overrunErr, 1);
        for (int i = 0; i < 16; i++) rd();
        tick();
        check("t6_rxEmpty", bus_e.rxEmpty, 1);
        clr_err();
        check("t6_overrun_clr", bus_e.overrunErr, 0);

        // 17th stop sample coincides with a pop: no overrun
        for (int i = 0; i < 16; i++) begin
            q_rx.push_back(8'(8'h60 + i));
            send_frame(8'(8'h60 + i), 0, 0);
        end
        q_rx.push_back(8'h70);
        fork
            send_frame(8'h70, 0, 0);
            begin
                repeat (171) @(posedge clk);
                #1 bus_e.rxRdEn = 1'b1;
                @(posedge clk);
                #1 bus_e.rxRdEn = 1'b0;
            end
        join
        repeat (4) tick();
        check("t6b_overrunErr", bus_e.overrunErr, 0);
        check("t6b_rxLevel", bus_e.rxLevel, 16);
        for (int i = 0; i < 16; i++) rd();
        tick();
        check("t6b_rxEmpty", bus_e.rxEmpty, 1);
        check("t6b_all_read", q_rx.size(), 0);

        // asynchronous reset in the middle of a frame
        push(1, 8'h00);
        repeat (40) tick();
        check("t7_mid_frame_low", bus_e.txOut, 0);
        check("t7_mid_frame_busy", bus_e.txBusy, 1);
        #2 rst = 1'b1;
        #1;
        check("t7_async_txOut", bus_e.txOut, 1);
        check("t7_async_busy", bus_e.txBusy, 0);
        check("t7_async_level", bus_e.txLevel, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) tick();
        check("t7_txOut_idle", bus_e.txOut, 1);

        summary();
        $finish;
    end
endmodule

// File: doc/uart_link.md
Name: uart_link

Overview:
- Parametrised UART transceiver that replaces the fixed 9600-baud 8N1 tx/rx core pair used by the command/display path.
- Adds run-time-independent, elaboration-time-configurable data width, parity, stop bits and baud rate.
- Adds TX and RX FIFOs so formatters and command controllers can burst bytes without waiting on the bit timing.
- Adds framing, parity and overrun error reporting.

Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BPS, 9600: line baud rate.
- DATA_BITS, 8: character width; legal values 5..8.
- PARITY, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits transmitted; legal values 1 or 2. RX checks only the first stop bit.
- TX_DEPTH, 16: TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 16: RX FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rxIn  in  1  serial receive line, asynchronous to clk.
- txOut  out  1  serial transmit line; idles high.
- txWrEn  in  1  push txWrData into the TX FIFO.
- txWrData  in  DATA_BITS  byte to send, LSB first on the line.
- txFull  out  1  TX FIFO full.
- txLevel  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- txBusy  out  1  a frame is in progress on txOut.
- rxRdEn  in  1  pop the RX FIFO head.
- rxRdData  out  DATA_BITS  RX FIFO head (show-ahead); valid while rxEmpty=0.
- rxEmpty  out  1  RX FIFO empty.
- rxLevel  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
- errClr  in  1  clears all sticky error flags.
- frameErr  out  1  sticky: stop bit sampled low.
- parityErr  out  1  sticky: parity mismatch.
- overrunErr  out  1  sticky: a byte completed while the RX FIFO was full.

Behaviour:
- Reset values:
  - txOut=1; txBusy=0.
  - txFull=0, txLevel=0; rxEmpty=1, rxLevel=0.
  - rxRdData=0; all error flags 0.
  - Both FSMs in IDLE.
  - Reset is asynchronous: asserting rst mid-frame forces txOut high immediately and discards FIFO contents and any partial RX character.
- Baud timing:
  - 16x oversample tick every DIV = round(CLK_FREQ/(BPS*16)) clocks, with DIV of at least 1.
  - TX and RX use independent tick counters; the RX counter restarts on start-edge detection.
  - One bit lasts 16 ticks.
- TX FIFO:
  - Push is ignored when txFull=1, judged on the current level, even if the TX FSM pops in the same cycle. An ignored push causes no state change.
  - The TX FSM pops internally.
- TX FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when PARITY=0.
  - IDLE: when txLevel≠0, pop the head and enter START. txBusy=1 from START through the end of STOP.
  - START: txOut=0.
  - DATA: sends DATA_BITS bits, LSB first.
  - PARITY: odd mode makes the total count of ones (data+parity) odd; even mode makes it even.
  - STOP: txOut=1 for STOP_BITS×16 ticks.
  - Latency: a push at cycle N into an empty FIFO with the FSM idle gives txLevel=1 at N+1, and txOut falls at N+2.
  - Back-to-back: if the FIFO is non-empty at the end of STOP, the next START follows with no idle gap.
- RX path:
  - rxIn passes through a 2-FF synchronizer; all decisions use the synchronized value.
  - IDLE: a falling edge enters START.
  - START: sample at tick 8. If high, it is a glitch: return to IDLE with nothing stored.
  - DATA: sample each bit at tick 8 of its bit period, LSB first.
  - PARITY: check the parity bit.
  - STOP: sample the first stop bit at tick 8.
- RX completion, evaluated on the stop-bit sample cycle:
  - Stop bit low: set frameErr and discard the character. Wait for the synchronized line to be high, then return to IDLE (break tolerance).
  - Parity mismatch: set parityErr; the character is still stored.
  - RX FIFO full: drop the character and set overrunErr. Exception: if rxRdEn pops in the same cycle, the push succeeds and no overrun is flagged.
  - Otherwise: push the character. rxEmpty falls and rxLevel increments on the next cycle.
  - RX then returns to IDLE and may detect a new start edge during the remainder of the stop bit.
- RX FIFO read:
  - rxRdEn while rxEmpty=1 is ignored.
  - rxRdData updates to the next entry the cycle after a pop.
- Error flags:
  - Sticky until errClr.
  - An error event coinciding with errClr wins: the flag stays set.
- Widths: data is zero-extended nowhere. Unused upper bits do not exist, since everything is sized to DATA_BITS.

Test Plan:
- All scenarios use CLK_FREQ=1_600_000 and BPS=100_000 (DIV=1, 16 clocks per bit).
- Reset, then one push of 0xA5 with 8N1: txOut falls 2 cycles later. LSB-first pattern 0,1,0,1,0,0,1,0,1,1 is observed, 16 clocks per bit; txBusy=1 for 160 cycles; txLevel returns to 0.
- Push 17 bytes 0x00..0x10 in consecutive cycles with TX_DEPTH=16: one byte pops at N+1, so 0x10 is accepted. After a further push while txFull=1, the ignored byte never appears. All frames are back-to-back with no idle gap.
- Loop txOut to rxIn with PARITY=2, sending 0x3C: the parity bit transmitted is 0. rxRdData=0x3C, rxEmpty=0, parityErr=0. After rxRdEn, rxEmpty=1.
- Drive a frame with the parity bit inverted: byte stored, parityErr=1. Then assert errClr: parityErr=0.
- Drive 0x55 with the stop bit held low for 3 bit times: frameErr=1, rxLevel unchanged, and the following valid 0x12 is received correctly.
- Receive 17 frames without reading (RX_DEPTH=16): rxLevel=16, overrunErr=1, and the first 16 bytes read back in order. Repeat with rxRdEn coinciding with the 17th stop-sample: no overrun.
